// File: rtl/snes_pad_reader.sv
// SNES gamepad reader: pulses LATCH, clocks out 16 button bits plus a presence bit,
// and publishes the decoded word atomically once per poll period.
module snes_pad_reader #(
    parameter int unsigned C_latch_cycles = 258,
    parameter int unsigned C_half_cycles  = 129,
    parameter int unsigned C_poll_cycles  = 357955
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic        pad_latch_o,
    output logic        pad_clk_o,
    input  logic        pad_data_i,
    output logic [15:0] buttons_o,
    output logic        valid_o,
    output logic        present_o
);

    localparam int unsigned TMax = (C_latch_cycles > C_half_cycles) ? C_latch_cycles
                                                                     : C_half_cycles;
    localparam int unsigned TW = (TMax > 1) ? $clog2(TMax) : 1;
    localparam int unsigned PW = (C_poll_cycles > 1) ? $clog2(C_poll_cycles) : 1;

    localparam logic [TW-1:0] LatchLoad = TW'(C_latch_cycles - 1);
    localparam logic [TW-1:0] HalfLoad  = TW'(C_half_cycles - 1);
    localparam logic [PW-1:0] PollLast  = PW'(C_poll_cycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StGap,
        StClkLo,
        StClkHi,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [4:0]    bit_q, bit_d;
    logic [16:0]   shift_q, shift_d;
    logic [1:0]    sync_q;
    logic [15:0]   buttons_q, buttons_d;
    logic          present_q, present_d;
    logic          valid_q, valid_d;
    logic          sample;
    logic          tmr_done;

    assign tmr_done = (tmr_q == '0);
    assign poll_d   = (poll_q == PollLast) ? '0 : poll_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q - TW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        buttons_d   = buttons_q;
        present_d   = present_q;
        valid_d     = 1'b0;
        sample      = 1'b0;
        pad_latch_o = 1'b0;
        pad_clk_o   = 1'b1;

        unique case (state_q)
            StIdle: begin
                tmr_d = tmr_q;
                if (poll_q == '0 && enable_i) begin
                    state_d = StLatch;
                    tmr_d   = LatchLoad;
                    bit_d   = '0;
                end
            end
            StLatch: begin
                pad_latch_o = 1'b1;
                if (tmr_done) begin
                    state_d = StGap;
                    tmr_d   = HalfLoad;
                end
            end
            StGap: begin
                if (tmr_done) begin
                    sample  = 1'b1;
                    state_d = StClkLo;
                    tmr_d   = HalfLoad;
                end
            end
            StClkLo: begin
                pad_clk_o = 1'b0;
                if (tmr_done) begin
                    state_d = StClkHi;
                    tmr_d   = HalfLoad;
                end
            end
            StClkHi: begin
                if (tmr_done) begin
                    sample  = 1'b1;
                    state_d = (bit_q == 5'd16) ? StDone : StClkLo;
                    tmr_d   = HalfLoad;
                end
            end
            StDone: begin
                // Pad drives low for pressed; bit 16 low means a pad is attached.
                buttons_d = ~shift_q[15:0];
                present_d = ~shift_q[16];
                valid_d   = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (sample) begin
            shift_d = {sync_q[1], shift_q[16:1]};
            bit_d   = bit_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            poll_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '1;
            sync_q    <= 2'b11;
            buttons_q <= '0;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            poll_q    <= poll_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sync_q    <= {sync_q[0], pad_data_i};
            buttons_q <= buttons_d;
            present_q <= present_d;
            valid_q   <= valid_d;
        end
    end

    // valid is registered alongside buttons/present so the pulse and new word coincide.
    assign buttons_o = buttons_q;
    assign present_o = present_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: behavioural pad model, frame-geometry monitor,
// table and random frames, plus reset/enable/glitch corner sequences.
module tb_snes_pad_reader;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b1;
    logic        pad_latch_o, pad_clk_o;
    logic        pad_data_i;
    logic [15:0] buttons_o;
    logic        valid_o, present_o;

    int checks = 0;
    int errors = 0;

    // Pad model state
    logic        pad_present = 1'b1;
    logic [15:0] press = 16'h0000;
    logic        glitch = 1'b0;
    logic        pad_drv = 1'b1;
    int          pad_idx = 0;
    logic        pad_prev_clk = 1'b1;

    // Monitor state
    int   cyc = 0;
    int   latch_rise_cyc = -1;
    int   rise_count = 0;
    int   latch_w = 0;
    int   lo_cnt = 0;
    int   lo_w = 0;
    logic lo_bad = 1'b0;
    logic mon_prev_latch = 1'b0;
    logic mon_prev_clk = 1'b1;
    logic [15:0] prev_b = 16'h0;
    logic        prev_p = 1'b0;

    assign pad_data_i = pad_drv & ~glitch;

    snes_pad_reader #(
        .C_latch_cycles(4),
        .C_half_cycles (2),
        .C_poll_cycles (100)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .pad_latch_o(pad_latch_o),
        .pad_clk_o  (pad_clk_o),
        .pad_data_i (pad_data_i),
        .buttons_o  (buttons_o),
        .valid_o    (valid_o),
        .present_o  (present_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a connected pad reports its pressed set; a missing pad reads as nothing.
    task automatic ref_model(input logic pres, input logic [15:0] pr,
                             output logic [15:0] b, output logic p);
        b = pres ? pr : 16'h0000;
        p = pres;
    endtask

    // Pad: LATCH reloads, each CLOCK falling edge shifts to the next bit, low after 16.
    always @(negedge clk) begin
        if (pad_latch_o === 1'b1) pad_idx = 0;
        else if (pad_prev_clk === 1'b1 && pad_clk_o === 1'b0) pad_idx++;
        pad_prev_clk = pad_clk_o;
        if (!pad_present) pad_drv = 1'b1;
        else if (pad_idx < 16) pad_drv = ~press[pad_idx];
        else pad_drv = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (pad_latch_o === 1'b1 && mon_prev_latch !== 1'b1) begin
            latch_rise_cyc = cyc;
            rise_count++;
            latch_w = 0;
            lo_cnt = 0;
            lo_bad = 1'b0;
        end
        if (pad_latch_o === 1'b1) latch_w++;
        if (pad_clk_o === 1'b0) begin
            if (mon_prev_clk === 1'b1) begin
                lo_cnt++;
                lo_w = 0;
            end
            lo_w++;
        end else if (mon_prev_clk === 1'b0 && lo_w != 2) begin
            lo_bad = 1'b1;
        end
        if ((buttons_o !== prev_b || present_o !== prev_p) && reset_i === 1'b0)
            chk("atomic_update", {31'd0, valid_o}, 32'd1);
        if (valid_o === 1'b1) begin
            chk("frame_len", cyc - latch_rise_cyc, 71);
            chk("latch_width", latch_w, 4);
            chk("clk_pulses", lo_cnt, 16);
            chk("clk_low_width_bad", {31'd0, lo_bad}, 32'd0);
        end
        mon_prev_latch = pad_latch_o;
        mon_prev_clk = pad_clk_o;
        prev_b = buttons_o;
        prev_p = present_o;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound);
        logic got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (valid_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("valid_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_rise(input int bound);
        int rc = rise_count;
        logic got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (rise_count != rc) begin
                got = 1'b1;
                break;
            end
        end
        chk("latch_rise_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_lo(input int n, input logic lvl);
        logic got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (lo_cnt == n && pad_clk_o === lvl) begin
                got = 1'b1;
                break;
            end
        end
        chk("phase_reached", {31'd0, got}, 32'd1);
    endtask

    typedef struct {
        logic        pres;
        logic [15:0] pr;
        logic [15:0] exp_b;
        logic        exp_p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] eb;
        logic        ep;
        int          t0;
        int          rc;
        logic        vseen;

        vecs[0] = '{pres: 1'b1, pr: 16'h0000, exp_b: 16'h0000, exp_p: 1'b1};
        vecs[1] = '{pres: 1'b1, pr: 16'h0889, exp_b: 16'h0889, exp_p: 1'b1};
        vecs[2] = '{pres: 1'b0, pr: 16'h5A5A, exp_b: 16'h0000, exp_p: 1'b0};
        vecs[3] = '{pres: 1'b1, pr: 16'hFFFF, exp_b: 16'hFFFF, exp_p: 1'b1};
        vecs[4] = '{pres: 1'b1, pr: 16'hA5C3, exp_b: 16'hA5C3, exp_p: 1'b1};
        vecs[5] = '{pres: 1'b0, pr: 16'h0000, exp_b: 16'h0000, exp_p: 1'b0};

        // Reset state
        repeat (4) step();
        chk("rst_latch", {31'd0, pad_latch_o}, 32'd0);
        chk("rst_clk", {31'd0, pad_clk_o}, 32'd1);
        chk("rst_buttons", {16'd0, buttons_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_present", {31'd0, present_o}, 32'd0);

        // First frame straight out of reset, nothing pressed
        reset_i = 1'b0;
        chk("latch_before_start", {31'd0, pad_latch_o}, 32'd0);
        step();
        chk("latch_first_cycle", {31'd0, pad_latch_o}, 32'd1);
        t0 = latch_rise_cyc;
        wait_valid(250);
        chk("f1_buttons", {16'd0, buttons_o}, 32'h0000);
        chk("f1_present", {31'd0, present_o}, 32'd1);
        wait_rise(200);
        chk("poll_period", latch_rise_cyc - t0, 100);
        wait_valid(250);
        chk("f2_buttons", {16'd0, buttons_o}, 32'h0000);

        // Table frames
        for (int i = 0; i < 6; i++) begin
            pad_present = vecs[i].pres;
            press = vecs[i].pr;
            wait_valid(250);
            chk($sformatf("vec%0d_buttons", i), {16'd0, buttons_o}, {16'd0, vecs[i].exp_b});
            chk($sformatf("vec%0d_present", i), {31'd0, present_o}, {31'd0, vecs[i].exp_p});
        end

        // Random frames
        for (int i = 0; i < 20; i++) begin
            pad_present = ($urandom_range(0, 3) != 0);
            press = 16'($urandom);
            ref_model(pad_present, press, eb, ep);
            wait_valid(250);
            chk($sformatf("rnd%0d_buttons", i), {16'd0, buttons_o}, {16'd0, eb});
            chk($sformatf("rnd%0d_present", i), {31'd0, present_o}, {31'd0, ep});
        end

        // Glitches relative to sample points
        pad_present = 1'b1;
        press = 16'h0000;
        wait_rise(150);
        wait_lo(3, 1'b0);
        glitch = 1'b1;
        step();
        glitch = 1'b0;
        wait_lo(6, 1'b1);
        glitch = 1'b1;
        step();
        step();
        glitch = 1'b0;
        wait_lo(9, 1'b0);
        step();
        glitch = 1'b1;
        step();
        step();
        step();
        glitch = 1'b0;
        wait_valid(250);
        chk("glitch_buttons", {16'd0, buttons_o}, 32'h0200);

        // Reset during CLK_LO of bit 5
        press = 16'h0F0F;
        wait_valid(250);
        chk("pre_rst_buttons", {16'd0, buttons_o}, 32'h0F0F);
        wait_rise(150);
        wait_lo(5, 1'b0);
        reset_i = 1'b1;
        step();
        chk("midrst_clk", {31'd0, pad_clk_o}, 32'd1);
        chk("midrst_latch", {31'd0, pad_latch_o}, 32'd0);
        chk("midrst_buttons", {16'd0, buttons_o}, 32'd0);
        chk("midrst_present", {31'd0, present_o}, 32'd0);
        vseen = valid_o;
        step();
        vseen |= valid_o;
        step();
        vseen |= valid_o;
        chk("midrst_no_valid", {31'd0, vseen}, 32'd0);
        reset_i = 1'b0;
        step();
        chk("postrst_latch", {31'd0, pad_latch_o}, 32'd1);
        wait_valid(250);
        chk("postrst_buttons", {16'd0, buttons_o}, 32'h0F0F);
        chk("postrst_present", {31'd0, present_o}, 32'd1);

        // Drop enable during LATCH
        press = 16'h3001;
        wait_rise(150);
        enable_i = 1'b0;
        t0 = latch_rise_cyc;
        wait_valid(250);
        chk("endrop_buttons", {16'd0, buttons_o}, 32'h3001);
        rc = rise_count;
        vseen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            vseen |= valid_o;
        end
        chk("disabled_no_latch", rise_count - rc, 0);
        chk("disabled_no_valid", {31'd0, vseen}, 32'd0);
        enable_i = 1'b1;
        wait_rise(150);
        chk("reenable_slot", latch_rise_cyc - t0, 300);
        wait_valid(250);
        chk("reenable_buttons", {16'd0, buttons_o}, 32'h3001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
